reg_writeback_unit: RTL and testbench
=====================================

Name: reg_writeback_unit

Overview:
- Write-side master for the 32x64 register file: collects results from the ALU and the load/store unit and drives the file's single write port (write enable, 5-bit address, 64-bit data).
- ALU results have priority. Load results are buffered in a small FIFO and drain into idle write slots.
- Also keeps a per-register pending-write scoreboard. Decode uses it to stall readers until the register file holds the committed value.

Parameters:
- LSU_DEPTH, 4, LSU result FIFO depth; power of 2, minimum 2.
- CNT_W, 2, width of each per-register pending counter; maximum 2^CNT_W-1 in-flight writes per register.
- XLEN, 64, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; always accepted, no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load result offered.
- lsu_ready  out  1  FIFO not full; transfer occurs when lsu_valid && lsu_ready.
- lsu_rd  in  5  load destination register.
- lsu_data  in  XLEN  load data.
- iss_valid  in  1  an instruction writing iss_rd issues this cycle.
- iss_rd  in  5  issuing destination register.
- iss_ready  out  1  issue permitted (pending counter of iss_rd not saturated).
- chk_rs1, chk_rs2  in  5 each  source registers queried by decode.
- rs1_busy, rs2_busy  out  1 each  combinational: the register has a write pending.
- rf_wr_en  out  1  register-file write enable (registered).
- rf_wr_addr  out  5  register-file write address (registered).
- rf_wr_data  out  XLEN  register-file write data (registered).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0.
  - FIFO empty, so lsu_ready=1.
  - All pending counters 0, so busy outputs are 0 and iss_ready=1.
  - Reset asserted mid-operation discards buffered loads and pending state.
- Write selection, each cycle:
  - If alu_valid, the ALU result is selected.
  - Otherwise, if the FIFO is non-empty, the FIFO head is selected and popped.
  - Otherwise nothing is selected and rf_wr_en=0 next cycle.
- Output stage:
  - The selection is registered; the rf_* outputs change on the next posedge (latency 1 for ALU, at least 1 for loads).
  - rf_wr_en=1 only if a source was selected and its rd != 0.
  - A write to x0 is consumed (and popped, if from the FIFO) but never reaches the register file.
- LSU FIFO:
  - lsu_ready = (count < LSU_DEPTH), registered state only.
  - Push and pop in the same cycle keep count unchanged. When full, lsu_ready=0 even if a pop occurs that cycle.
  - Pointers wrap modulo LSU_DEPTH.
  - Order is preserved: loads write back in arrival order.
- Pending counters (x1..x31; x0 is never pending):
  - inc = iss_valid && iss_ready && iss_rd != 0.
  - dec = rf_wr_en && rf_wr_addr matches; counted at the edge the register file captures the write.
  - inc and dec on the same register in the same cycle: counter unchanged.
  - dec at 0 is a protocol violation: counter holds 0; simulation assertion fires.
  - iss_ready = 0 when counter[iss_rd] == 2^CNT_W-1 (combinational); iss_ready is 1 for iss_rd=0.
- Busy outputs:
  - rsN_busy = (counter[chk_rsN] != 0); always 0 for x0.
  - Busy drops the cycle after rf_wr_en, so a register-file read that cycle returns the new value.
- Simultaneous ALU arrival and non-empty FIFO: ALU wins; the FIFO holds. A continuous ALU stream can starve loads; the decode stall via busy bounds this.

Decomposition:
- Shared package: XLEN, REG_ADDR_W=5, NUM_REGS=32, and a wb_req struct {valid, rd, data} used by both sources and the output stage.
- One natural sub-module: wb_sync_fifo (parameterised depth/width, valid/ready push, pop-enable, count). Arbitration, output register and scoreboard stay in the top.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> rf_wr_en=0, lsu_ready=1, iss_ready=1, busy=0. Release -> outputs remain idle.
- ALU path: iss x5, then alu_valid rd=5 data=0xDEAD_BEEF -> next cycle rf_wr_en=1, addr=5, data=0xDEADBEEF. rs1_busy(x5) is 1 until the cycle after, then 0.
- Contention: alu_valid rd=3 and lsu push rd=4 data=0x11 in the same cycle -> x3 written at cycle+1, x4 at cycle+2.
- FIFO full: 4 loads pushed while alu_valid is held 1 -> lsu_ready=0 on the 5th. Drop alu_valid -> writes drain in order, one per cycle; lsu_ready returns 1 after the first pop.
- x0 and saturation:
  - alu_valid rd=0 -> rf_wr_en stays 0.
  - Three issues to x7 without writeback -> iss_ready=0 for iss_rd=7, while iss_rd=8 is still ready.
  - Issue x7 in the same cycle as a write to x7 -> counter unchanged.
- Async reset mid-drain: rst_n low with 2 loads buffered -> rf_wr_en drops immediately; after release, no stale writes appear.

Source files
------------

// File: rtl/reg_writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_writeback_unit_pkg
//  Description : Shared types and constants for the register write-back unit.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_writeback_unit_pkg;

   localparam int WB_XLEN    = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // One write-back request: a source offering (or the output stage holding)
   // a result destined for register rd.
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_XLEN-1:0]    data;
   } wb_req_t;

   // A request that actually reaches the register file: x0 is discarded.
   function automatic logic wb_writes_rf(input wb_req_t req);
      return req.valid && (req.rd != '0);
   endfunction

endpackage : reg_writeback_unit_pkg
`default_nettype wire

// File: rtl/reg_writeback_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sync_fifo
//  Description : Single-clock FIFO with valid/ready push, pop-enable and an
//                occupancy count. DEPTH must be a power of two, >= 2.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop_en,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CW-1:0]    CNT_ONE = CW'(1);
   localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Ready reflects registered occupancy only; a same-cycle pop does not help.
   always_comb begin
      push_ready = (count != CNT_FULL);
      do_push    = push_valid && push_ready;
      do_pop     = pop_en && (count != '0);
      pop_data   = mem[rd_ptr];
   end

   // Storage array; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_ONE;
         end else if (do_pop && !do_push) begin
            count <= count - CNT_ONE;
         end
      end
   end

endmodule : wb_sync_fifo
`default_nettype wire

// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : reg_writeback_unit
//  Description : Write-port master for the 32x64 register file. Arbitrates
//                ALU results (priority) against buffered load results and
//                tracks per-register pending writes for decode stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_writeback_unit
   import reg_writeback_unit_pkg::*;
#(
   parameter int LSU_DEPTH = 4,
   parameter int CNT_W     = 2,
   parameter int XLEN      = WB_XLEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_data,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_rd,
   output logic                  iss_ready,
   input  logic [REG_ADDR_W-1:0] chk_rs1,
   input  logic [REG_ADDR_W-1:0] chk_rs2,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  rf_wr_en,
   output logic [REG_ADDR_W-1:0] rf_wr_addr,
   output logic [XLEN-1:0]       rf_wr_data
);

   localparam int FIFO_W = REG_ADDR_W + XLEN;
   localparam int FCNT_W = $clog2(LSU_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   wb_req_t               alu_req;
   wb_req_t               fifo_req;
   wb_req_t               sel_req;
   logic [FIFO_W-1:0]     fifo_head;
   logic [FCNT_W-1:0]     fifo_count;
   logic                  fifo_pop;

   logic [CNT_W-1:0]      pend [NUM_REGS];
   logic [NUM_REGS-1:0]   inc_vec;
   logic [NUM_REGS-1:0]   dec_vec;
   logic                  do_inc;

   // ------------------------------------------------------------------------
   // Load result buffer
   // ------------------------------------------------------------------------
   wb_sync_fifo #(
      .DEPTH (LSU_DEPTH),
      .WIDTH (FIFO_W)
   ) u_lsu_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (lsu_valid),
      .push_ready (lsu_ready),
      .push_data  ({lsu_rd, lsu_data}),
      .pop_en     (fifo_pop),
      .pop_data   (fifo_head),
      .count      (fifo_count)
   );

   // ALU wins; the FIFO head is only consumed in a slot the ALU leaves idle.
   always_comb begin
      alu_req.valid  = alu_valid;
      alu_req.rd     = alu_rd;
      alu_req.data   = alu_data;
      fifo_req.valid = (fifo_count != '0);
      fifo_req.rd    = fifo_head[FIFO_W-1:XLEN];
      fifo_req.data  = fifo_head[XLEN-1:0];
      fifo_pop       = 1'b0;
      if (alu_req.valid) begin
         sel_req = alu_req;
      end else begin
         sel_req  = fifo_req;
         fifo_pop = fifo_req.valid;
      end
   end

   // Output stage: register the selection; x0 writes are swallowed here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
      end else begin
         rf_wr_en <= wb_writes_rf(sel_req);
         if (sel_req.valid) begin
            rf_wr_addr <= sel_req.rd;
            rf_wr_data <= sel_req.data;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Pending-write scoreboard
   // ------------------------------------------------------------------------

   // Issue gating and one-hot increment/decrement decode per register.
   always_comb begin
      iss_ready = (iss_rd == '0) || (pend[iss_rd] != CNT_MAX);
      do_inc    = iss_valid && iss_ready && (iss_rd != '0);
      inc_vec   = '0;
      dec_vec   = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         inc_vec[i] = do_inc && (iss_rd == REG_ADDR_W'(i));
         dec_vec[i] = rf_wr_en && (rf_wr_addr == REG_ADDR_W'(i));
      end
   end

   // Counters; x0 stays at zero, and a decrement at zero is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            pend[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
               pend[i] <= pend[i] + CNT_ONE;
            end else if (dec_vec[i] && !inc_vec[i] && (pend[i] != '0)) begin
               pend[i] <= pend[i] - CNT_ONE;
            end
         end
      end
   end

   // Busy lookups for decode; pend[0] is permanently zero.
   always_comb begin
      rs1_busy = (pend[chk_rs1] != '0);
      rs2_busy = (pend[chk_rs2] != '0);
   end

   // A write-back to a register with nothing pending indicates an issue bug.
   generate
      for (genvar g = 1; g < NUM_REGS; g++) begin : g_pend_assert
         assert property (@(posedge clk) disable iff (!rst_n)
            !(dec_vec[g] && !inc_vec[g] && (pend[g] == '0)))
            else $error("reg_writeback_unit: write-back to x%0d with no pending issue", g);
      end
   endgenerate

endmodule : reg_writeback_unit
`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_writeback_unit
//  Description : Directed self-checking bench for reg_writeback_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [63:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [63:0] lsu_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic [4:0]  chk_rs1;
   logic [4:0]  chk_rs2;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [63:0] rf_wr_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   reg_writeback_unit #(
      .LSU_DEPTH (4),
      .CNT_W     (2),
      .XLEN      (64)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_rd     (lsu_rd),
      .lsu_data   (lsu_data),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .iss_ready  (iss_ready),
      .chk_rs1    (chk_rs1),
      .chk_rs2    (chk_rs2),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy),
      .rf_wr_en   (rf_wr_en),
      .rf_wr_addr (rf_wr_addr),
      .rf_wr_data (rf_wr_data)
   );

   // Advance one clock and settle 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      iss_valid = 1'b0; iss_rd = '0;
   endtask

   task automatic issue(input logic [4:0] rd);
      iss_valid = 1'b1; iss_rd = rd;
      tick();
      iss_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = {$urandom, $urandom};
         lsu_valid = 1'($urandom); lsu_rd = 5'($urandom); lsu_data = {$urandom, $urandom};
         iss_valid = 1'($urandom); iss_rd = 5'($urandom);
         chk_rs1 = 5'($urandom); chk_rs2 = 5'($urandom);
         tick();
         n_checks++;
         if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_rf: en=%b addr=%0d data=%h, required 0/0/0", rf_wr_en, rf_wr_addr, rf_wr_data);
         end
         n_checks++;
         if (lsu_ready !== 1'b1 || iss_ready !== 1'b1 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: lsu_ready=%b iss_ready=%b busy=%b%b, required 1 1 00",
                     lsu_ready, iss_ready, rs1_busy, rs2_busy);
         end
      end
      idle_inputs();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_rs1 = 5'($urandom); chk_rs2 = 5'($urandom);
         #1;
         n_checks++;
         if (rf_wr_en !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || lsu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: en=%b busy=%b%b lsu_ready=%b, required 0 00 1",
                     rf_wr_en, rs1_busy, rs2_busy, lsu_ready);
         end
      end
   endtask

   task automatic test_alu_path();
      chk_rs1 = 5'd5;
      issue(5'd5);
      n_checks++;
      if (rs1_busy !== 1'b1) begin
         n_fail++; $display("FAIL alu_busy_after_issue: got %b, required 1", rs1_busy);
      end
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF;
      tick();
      alu_valid = 1'b0;
      n_checks++;
      if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 64'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL alu_write: en=%b addr=%0d data=%h, required 1/5/00000000deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data);
      end
      n_checks++;
      if (rs1_busy !== 1'b1) begin
         n_fail++; $display("FAIL alu_busy_during_write: got %b, required 1", rs1_busy);
      end
      tick();
      n_checks++;
      if (rf_wr_en !== 1'b0 || rs1_busy !== 1'b0) begin
         n_fail++; $display("FAIL alu_after_write: en=%b busy=%b, required 0 0", rf_wr_en, rs1_busy);
      end
   endtask

   task automatic test_contention();
      issue(5'd3);
      issue(5'd4);
      chk_rs1 = 5'd3; chk_rs2 = 5'd4;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'h11;
      #1;
      n_checks++;
      if (lsu_ready !== 1'b1) begin
         n_fail++; $display("FAIL cont_lsu_ready: got %b, required 1", lsu_ready);
      end
      tick();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      n_checks++;
      if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd3 || rf_wr_data !== 64'h33) begin
         n_fail++; $display("FAIL cont_first: en=%b addr=%0d data=%h, required 1/3/33", rf_wr_en, rf_wr_addr, rf_wr_data);
      end
      tick();
      n_checks++;
      if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd4 || rf_wr_data !== 64'h11) begin
         n_fail++; $display("FAIL cont_second: en=%b addr=%0d data=%h, required 1/4/11", rf_wr_en, rf_wr_addr, rf_wr_data);
      end
      n_checks++;
      if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1) begin
         n_fail++; $display("FAIL cont_busy_mid: busy=%b%b, required 01", rs1_busy, rs2_busy);
      end
      tick();
      n_checks++;
      if (rf_wr_en !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
         n_fail++; $display("FAIL cont_end: en=%b busy=%b%b, required 0 00", rf_wr_en, rs1_busy, rs2_busy);
      end
   endtask

   task automatic test_fifo_full();
      for (int r = 10; r < 14; r++) issue(5'(r));
      // ALU stream to x0 occupies every slot but never writes the file.
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
      for (int k = 0; k < 4; k++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(10 + k); lsu_data = 64'hA0 + 64'(k);
         #1;
         n_checks++;
         if (lsu_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_ready_push%0d: got %b, required 1", k, lsu_ready);
         end
         tick();
      end
      lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_data = 64'hBAD;
      #1;
      n_checks++;
      if (lsu_ready !== 1'b0 || rf_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL full_ready_fifth: lsu_ready=%b en=%b, required 0 0", lsu_ready, rf_wr_en);
      end
      tick();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'(10 + k) || rf_wr_data !== 64'hA0 + 64'(k)) begin
            n_fail++;
            $display("FAIL drain%0d: en=%b addr=%0d data=%h, required 1/%0d/%h",
                     k, rf_wr_en, rf_wr_addr, rf_wr_data, 10 + k, 64'hA0 + 64'(k));
         end
         if (k == 0) begin
            n_checks++;
            if (lsu_ready !== 1'b1) begin
               n_fail++; $display("FAIL drain_ready: got %b, required 1", lsu_ready);
            end
         end
      end
      tick();
      n_checks++;
      if (rf_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL drain_empty: en=%b, required 0", rf_wr_en);
      end
   endtask

   task automatic test_x0_saturation();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
      tick();
      alu_valid = 1'b0;
      n_checks++;
      if (rf_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL x0_write: en=%b, required 0", rf_wr_en);
      end
      for (int k = 0; k < 3; k++) begin
         iss_valid = 1'b1; iss_rd = 5'd7;
         #1;
         n_checks++;
         if (iss_ready !== 1'b1) begin
            n_fail++; $display("FAIL sat_issue%0d: iss_ready=%b, required 1", k, iss_ready);
         end
         tick();
      end
      iss_valid = 1'b0; iss_rd = 5'd7;
      #1;
      n_checks++;
      if (iss_ready !== 1'b0) begin
         n_fail++; $display("FAIL sat_x7: iss_ready=%b, required 0", iss_ready);
      end
      iss_rd = 5'd8;
      #1;
      n_checks++;
      if (iss_ready !== 1'b1) begin
         n_fail++; $display("FAIL sat_x8: iss_ready=%b, required 1", iss_ready);
      end
      iss_rd = 5'd0;
      #1;
      n_checks++;
      if (iss_ready !== 1'b1) begin
         n_fail++; $display("FAIL sat_x0: iss_ready=%b, required 1", iss_ready);
      end
      // Retire one write to x7: 3 -> 2.
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h7;
      tick();
      alu_valid = 1'b0;
      tick();
      iss_rd = 5'd7;
      #1;
      n_checks++;
      if (iss_ready !== 1'b1) begin
         n_fail++; $display("FAIL sat_after_retire: iss_ready=%b, required 1", iss_ready);
      end
      // Write x7 while issuing x7: counter must stay at 2.
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
      tick();
      alu_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd7;
      #1;
      n_checks++;
      if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || iss_ready !== 1'b1) begin
         n_fail++; $display("FAIL same_cycle_setup: en=%b addr=%0d iss_ready=%b, required 1/7/1", rf_wr_en, rf_wr_addr, iss_ready);
      end
      tick();
      iss_valid = 1'b0;
      #1;
      n_checks++;
      if (iss_ready !== 1'b1) begin
         n_fail++; $display("FAIL same_cycle_not_inc: iss_ready=%b, required 1", iss_ready);
      end
      chk_rs1 = 5'd7;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h70;
      tick();
      alu_valid = 1'b0;
      tick();
      n_checks++;
      if (rs1_busy !== 1'b1) begin
         n_fail++; $display("FAIL same_cycle_not_dec: rs1_busy=%b, required 1", rs1_busy);
      end
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h71;
      tick();
      alu_valid = 1'b0;
      tick();
      n_checks++;
      if (rs1_busy !== 1'b0) begin
         n_fail++; $display("FAIL x7_cleared: rs1_busy=%b, required 0", rs1_busy);
      end
   endtask

   task automatic test_async_reset();
      issue(5'd20);
      issue(5'd21);
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = '0;
      lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 64'h2020;
      tick();
      lsu_rd = 5'd21; lsu_data = 64'h2121;
      tick();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      tick();
      chk_rs1 = 5'd20; chk_rs2 = 5'd21;
      #1;
      n_checks++;
      if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd20) begin
         n_fail++; $display("FAIL ar_first_drain: en=%b addr=%0d, required 1/20", rf_wr_en, rf_wr_addr);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (rf_wr_en !== 1'b0 || lsu_ready !== 1'b1 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_immediate: en=%b lsu_ready=%b busy=%b%b, required 0 1 00", rf_wr_en, lsu_ready, rs1_busy, rs2_busy);
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (rf_wr_en !== 1'b0 || rs2_busy !== 1'b0) begin
            n_fail++; $display("FAIL ar_no_stale%0d: en=%b busy=%b, required 0 0", k, rf_wr_en, rs2_busy);
         end
      end
   endtask

   initial begin
      idle_inputs();
      chk_rs1 = '0; chk_rs2 = '0;
      rst_n = 1'b0;
      #2;
      test_reset();
      test_alu_path();
      test_contention();
      test_fifo_full();
      test_x0_saturation();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_reg_writeback_unit
`default_nettype wire
